// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned MAX_ADDR_W = 32;

    localparam logic [MAX_ADDR_W-1:0] ZERO_REG_ADDR = '0;

    // True when addr names the hardwired zero register and that feature is enabled.
    function automatic logic is_zero(input logic [MAX_ADDR_W-1:0] addr, input logic zero_en);
        return zero_en && (addr == ZERO_REG_ADDR);
    endfunction

endpackage

// File: rtl/regfile_rport.sv
// One asynchronous read port: zero-register mux, write-first bypass and busy qualification.
module regfile_rport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter bit          ZERO_REG = 1'b1,
    localparam int unsigned DEPTH   = 1 << ADDR_W
) (
    input  logic [ADDR_W-1:0] ra,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [DATA_W-1:0] mem [DEPTH],
    input  logic [DEPTH-1:0]  sb,
    output logic [DATA_W-1:0] rd_c,
    output logic              busy_c
);

    logic zero_hit;
    logic byp_hit;

    always_comb begin
        zero_hit = is_zero(MAX_ADDR_W'(ra), ZERO_REG);
        byp_hit  = we && (wa == ra);
        rd_c     = mem[ra];
        busy_c   = sb[ra];
        if (zero_hit) begin
            rd_c   = '0;
            busy_c = 1'b0;
        end else if (byp_hit) begin
            // The in-flight write both supplies the data and retires the pending producer.
            rd_c   = wd;
            busy_c = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-first bypass, optional zero register,
// per-register busy scoreboard and a registered debug read port.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NRD      = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rbusy,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wa,
    input  logic [DATA_W-1:0]     wd,
    input  logic                  iss_v,
    input  logic [ADDR_W-1:0]     iss_a,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     dbg_a,
    output logic [DATA_W-1:0]     dbg_d
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  sb_q;
    logic [DEPTH-1:0]  sb_d;
    logic [DATA_W-1:0] dbg_rd_q;
    logic [DATA_W-1:0] dbg_rd_d;
    logic              wr_ok;
    logic              iss_ok;

    always_comb begin
        wr_ok  = we && !is_zero(MAX_ADDR_W'(wa), ZERO_REG);
        iss_ok = iss_v && !is_zero(MAX_ADDR_W'(iss_a), ZERO_REG);

        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wa] = wd;
        end

        // Ordering matters: flush, then write-clear, then issue-set so a new producer always wins.
        sb_d = sb_q;
        if (flush) begin
            sb_d = '0;
        end
        if (wr_ok) begin
            sb_d[wa] = 1'b0;
        end
        if (iss_ok) begin
            sb_d[iss_a] = 1'b1;
        end

        dbg_rd_d = mem_q[dbg_a];
        if (is_zero(MAX_ADDR_W'(dbg_a), ZERO_REG)) begin
            dbg_rd_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            sb_q     <= '0;
            dbg_rd_q <= '0;
        end else begin
            mem_q    <= mem_d;
            sb_q     <= sb_d;
            dbg_rd_q <= dbg_rd_d;
        end
    end

    assign dbg_d = dbg_rd_q;

    for (genvar i = 0; i < NRD; i++) begin : g_rport
        regfile_rport #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) u_rport (
            .ra     (ra[i*ADDR_W +: ADDR_W]),
            .we     (we),
            .wa     (wa),
            .wd     (wd),
            .mem    (mem_q),
            .sb     (sb_q),
            .rd_c   (rd[i*DATA_W +: DATA_W]),
            .busy_c (rbusy[i])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default instance plus a 3-port instance without a zero register.
module tb_regfile_sb;

    logic clk;
    logic rst_n;

    // Instance A: NRD=2, ZERO_REG=1
    logic [9:0]  ra;
    logic [63:0] rd;
    logic [1:0]  rbusy;
    logic        we, iss_v, flush;
    logic [4:0]  wa, iss_a, dbg_a;
    logic [31:0] wd, dbg_d;

    // Instance B: NRD=3, ZERO_REG=0
    logic [14:0] ra_b;
    logic [95:0] rd_b;
    logic [2:0]  rbusy_b;
    logic        we_b, iss_v_b, flush_b;
    logic [4:0]  wa_b, iss_a_b, dbg_a_b;
    logic [31:0] wd_b, dbg_d_b;

    int n_checks;
    int n_errors;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .rbusy(rbusy),
        .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_a(iss_a),
        .flush(flush), .dbg_a(dbg_a), .dbg_d(dbg_d)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NRD(3), .ZERO_REG(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ra(ra_b), .rd(rd_b), .rbusy(rbusy_b),
        .we(we_b), .wa(wa_b), .wd(wd_b), .iss_v(iss_v_b), .iss_a(iss_a_b),
        .flush(flush_b), .dbg_a(dbg_a_b), .dbg_d(dbg_d_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        ra = '0; we = 1'b0; wa = '0; wd = '0; iss_v = 1'b0; iss_a = '0; flush = 1'b0; dbg_a = '0;
        ra_b = '0; we_b = 1'b0; wa_b = '0; wd_b = '0; iss_v_b = 1'b0; iss_a_b = '0; flush_b = 1'b0;
        dbg_a_b = '0;

        // Reset and zero register
        #12;
        check("reset_rd", 128'(rd), 128'h0);
        check("reset_rbusy", 128'(rbusy), 128'h0);
        check("reset_dbg", 128'(dbg_d), 128'h0);
        we = 1'b1; wa = 5'd0; wd = 32'hDEAD_BEEF; ra = {5'd0, 5'd0};
        #1;
        check("zero_rd_in_reset", 128'(rd[31:0]), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("zero_rd_bypass", 128'(rd[31:0]), 128'h0);
        check("zero_rbusy", 128'(rbusy[0]), 128'h0);
        we = 1'b0; dbg_a = 5'd0;
        step();
        check("zero_rd_stored", 128'(rd[31:0]), 128'h0);
        check("zero_dbg", 128'(dbg_d), 128'h0);

        // Bypass
        we = 1'b1; wa = 5'd7; wd = 32'h1234_5678; ra = {5'd7, 5'd7};
        #1;
        check("bypass_same_cycle", 128'(rd), 128'h1234_5678_1234_5678);
        step();
        we = 1'b0; dbg_a = 5'd7;
        #1;
        check("bypass_stored", 128'(rd), 128'h1234_5678_1234_5678);
        step();
        check("dbg_r7", 128'(dbg_d), 128'h1234_5678);

        // Scoreboard set / hold / bypass clear
        ra = {5'd9, 5'd0}; iss_v = 1'b1; iss_a = 5'd9;
        #1;
        check("sb_t0", 128'(rbusy[1]), 128'h0);
        step();
        iss_v = 1'b0;
        #1;
        check("sb_t1", 128'(rbusy[1]), 128'h1);
        step();
        check("sb_t2", 128'(rbusy[1]), 128'h1);
        step();
        we = 1'b1; wa = 5'd9; wd = 32'h0000_0055;
        #1;
        check("sb_t3_busy", 128'(rbusy[1]), 128'h0);
        check("sb_t3_rd", 128'(rd[63:32]), 128'h55);
        step();
        we = 1'b0;
        #1;
        check("sb_t4_busy", 128'(rbusy[1]), 128'h0);

        // WAW: write and issue to the same register on one edge
        iss_v = 1'b1; iss_a = 5'd4;
        step();
        iss_v = 1'b0; ra = {5'd0, 5'd4};
        #1;
        check("waw_pre_busy", 128'(rbusy[0]), 128'h1);
        we = 1'b1; wa = 5'd4; wd = 32'h0000_0044; iss_v = 1'b1; iss_a = 5'd4;
        #1;
        check("waw_bypass_busy", 128'(rbusy[0]), 128'h0);
        step();
        we = 1'b0; iss_v = 1'b0;
        #1;
        check("waw_busy_after", 128'(rbusy[0]), 128'h1);
        check("waw_data", 128'(rd[31:0]), 128'h44);

        // Flush plus issue (sb[4] is still set from above)
        iss_v = 1'b1; iss_a = 5'd3;
        step();
        iss_a = 5'd5;
        step();
        iss_v = 1'b0; ra = {5'd5, 5'd3};
        #1;
        check("flush_pre", 128'(rbusy), 128'h3);
        flush = 1'b1; iss_v = 1'b1; iss_a = 5'd6;
        step();
        flush = 1'b0; iss_v = 1'b0;
        #1;
        check("flush_r3_r5", 128'(rbusy), 128'h0);
        ra = {5'd4, 5'd6};
        #1;
        check("flush_r6_r4", 128'(rbusy), 128'h1);

        // Asynchronous reset mid-run
        we = 1'b1; wa = 5'd10; wd = 32'hA5A5_A5A5;
        step();
        we = 1'b0; iss_v = 1'b1; iss_a = 5'd10;
        step();
        iss_v = 1'b0; ra = {5'd0, 5'd10};
        #1;
        check("areset_pre_rd", 128'(rd[31:0]), 128'hA5A5_A5A5);
        check("areset_pre_busy", 128'(rbusy[0]), 128'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("areset_rd", 128'(rd[31:0]), 128'h0);
        check("areset_busy", 128'(rbusy[0]), 128'h0);
        #1;
        rst_n = 1'b1;
        step();
        check("areset_post_rd", 128'(rd[31:0]), 128'h0);

        // Instance B: register 0 is ordinary
        we_b = 1'b1; wa_b = 5'd0; wd_b = 32'h0000_0077; ra_b = {5'd0, 5'd0, 5'd0};
        #1;
        check("b_r0_bypass", 128'(rd_b), 128'h77_0000_0077_0000_0077);
        step();
        we_b = 1'b0; iss_v_b = 1'b1; iss_a_b = 5'd0; dbg_a_b = 5'd0;
        #1;
        check("b_r0_stored", 128'(rd_b), 128'h77_0000_0077_0000_0077);
        check("b_r0_not_busy_yet", 128'(rbusy_b), 128'h0);
        step();
        iss_v_b = 1'b0;
        #1;
        check("b_r0_busy", 128'(rbusy_b), 128'h7);
        check("b_dbg_r0", 128'(dbg_d_b), 128'h77);
        ra_b = {5'd0, 5'd3, 5'd0};
        #1;
        check("b_mixed_busy", 128'(rbusy_b), 128'h5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with write-first bypass, hardwired zero register, N asynchronous read ports, a per-register busy scoreboard for pending writes, and a registered debug read port. It replaces the fixed 32x32, 2-read-port register file in the CPU datapath. The scoreboard lets decode stall on RAW hazards against multi-cycle producers such as loads and the mul/div unit.

## Interface
- DATA_W, 32: register width in bits
- ADDR_W, 5: address width; depth = 2**ADDR_W
- NRD, 2: number of asynchronous read ports (1..4)
- ZERO_REG, 1: 1 = register 0 reads 0, is never written and is never busy; 0 = register 0 is ordinary
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- ra  in  NRD*ADDR_W  read addresses; port i = ra[i*ADDR_W +: ADDR_W]
- rd  out  NRD*DATA_W  read data; port i = rd[i*DATA_W +: DATA_W]
- rbusy  out  NRD  port i operand still pending
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- iss_v  in  1  mark register iss_a busy (producer issued)
- iss_a  in  ADDR_W  destination of issued producer
- flush  in  1  synchronously clear all busy bits
- dbg_a  in  ADDR_W  debug read address
- dbg_d  out  DATA_W  registered debug data

## Operation
- Storage: 2**ADDR_W x DATA_W flops plus 2**ADDR_W busy bits sb[].
- Reset (rst_n=0, asynchronous): all registers are 0, all sb are 0, and dbg_d is 0. rd then equals 0 for all ports, and rbusy equals 0.
- Write: on a rising edge with we=1, reg[wa] <= wd and sb[wa] <= 0. With ZERO_REG=1 and wa=0, the write is ignored.
- Read, combinational on each port i:
  - With ZERO_REG=1 and ra_i=0, the port returns 0.
  - Else, with we=1 and wa==ra_i, the port returns wd (write-first bypass).
  - Else, the port returns reg[ra_i].
- rbusy_i = sb[ra_i] & ~(we & wa==ra_i). It is forced to 0 for register 0 when ZERO_REG=1. A same-cycle iss_v does not affect rbusy; it is seen from the next cycle.
- Issue: on a rising edge with iss_v=1, sb[iss_a] <= 1. This is ignored for register 0 when ZERO_REG=1.
- Simultaneous events on one edge:
  - iss_v and we to the same address: the set wins (WAW; the new producer owns the register), and the data is still written.
  - flush and iss_v: flush clears all bits, then the iss_a bit is set. Flush never blocks a new issue.
  - flush and we: the data is written and all bits are cleared.
- Debug: dbg_d <= value of reg[dbg_a] as stored at the edge, with no bypass. With ZERO_REG=1 and dbg_a=0, it reads 0.
- Any read port may alias any other read port, the write port and dbg_a. The ports are independent.

## Timing
- Read ports and rbusy: 0-cycle combinational latency from ra, we, wa and wd.
- A write is visible through bypass in the same cycle, and from storage on the next cycle.
- Busy set: visible on rbusy 1 cycle after the iss_v edge. Busy clear: visible in the same cycle as the writing we (bypass).
- dbg_d: 1-cycle latency.
- Reset mid-operation: all state clears immediately regardless of clk. The first valid write is on the first rising edge after rst_n rises.
- No backpressure: every we, iss_v and flush is accepted on its edge.

## Structure
- Shared package `regfile_pkg`:
  - default DATA_W and ADDR_W
  - the ZERO_REG_ADDR constant
  - a function `is_zero(addr, zero_en)` used by the read, write, issue and scoreboard logic
- One sub-module: `regfile_rport` holds one read port's mux, bypass and busy logic. The top level instantiates it NRD times in a generate loop.
- The storage array and sb[] live in the top level. They use plain flops with an asynchronous clear.

## Test plan
- Reset and zero register:
  - Stimulus: hold rst_n=0, then release; write we=1, wa=0, wd=32'hDEAD_BEEF; read ra0=0.
  - Required: rd0=0 and rbusy0=0 throughout. After the release, dbg_a=0 gives dbg_d=0 one cycle later.
- Bypass:
  - Stimulus: we=1, wa=7, wd=32'h1234_5678, with ra0=7 and ra1=7 in the same cycle.
  - Required: rd0=rd1=32'h1234_5678 in that cycle. On the next cycle with we=0, both still read 32'h1234_5678.
- Scoreboard:
  - Stimulus: iss_v=1, iss_a=9 at edge t; hold ra1=9; write we=1, wa=9 at cycle t+3.
  - Required: rbusy1=0 in cycle t, 1 in cycles t+1..t+2, and 0 in cycle t+3 (cleared through bypass).
- WAW collision:
  - Stimulus: sb[4]=1; then on one edge apply we=1, wa=4 and iss_v=1, iss_a=4.
  - Required: reg[4] is updated, and rbusy for ra=4 stays 1 on the next cycle.
- Flush plus issue:
  - Stimulus: sb[3]=sb[5]=1; then on one edge apply flush=1 and iss_v=1, iss_a=6.
  - Required: on the next cycle rbusy is 0 for registers 3 and 5 and 1 for register 6.
- Asynchronous reset mid-run:
  - Stimulus: reg[10]=32'hA5A5_A5A5 and sb[10]=1; pulse rst_n low between clock edges.
  - Required: rd for ra=10 falls to 0 and rbusy falls to 0 without waiting for a clock edge.
  - Repeat with NRD=3 and ZERO_REG=0: register 0 is writable and becomes busy after an issue to it.
